multi_edge_pulse: RTL
=====================

Name: multi_edge_pulse

Overview:
- Parametrised, multi-channel successor to the single-channel level-to-pulse one-shot.
- Each channel can synchronise an asynchronous level input and detect rising, falling or both edges.
- Each detected edge produces an output pulse of programmable width, followed by an optional hold-off window that rejects further edges.
- Sits between raw switch/sensor inputs and control logic that needs clean, single-event strobes.

Parameters:
- CHANNELS, 4: number of independent level/pulse channels (>=1).
- SYNC_STAGES, 2: flip-flop synchroniser depth per channel. 0 means the input is used directly.
- PULSE_WIDTH, 1: output pulse length in clk cycles (>=1).
- HOLDOFF, 0: cycles after the pulse ends during which edges are ignored (>=0).
- RETRIGGER, 0: 1 means an edge seen during PULSE restarts the pulse counter. 0 means it is ignored.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- level  input  CHANNELS  per-channel level inputs; may be asynchronous when SYNC_STAGES>=1.
- mode  input  2*CHANNELS  per-channel edge select; channel i uses mode[2i+1:2i]. 00 = rising, 01 = falling, 10 = both, 11 = channel disabled.
- pulse  output  CHANNELS  registered per-channel pulse.
- busy  output  CHANNELS  registered; high while the channel is in PULSE or HOLD.
- any_pulse  output  1  combinational OR of pulse.

Behaviour:
- Reset, at a clk edge with rst=1:
  - Synchroniser flops, the previous-level register and all counters clear to 0.
  - Every channel goes to IDLE; pulse=0, busy=0, any_pulse=0.
- Reset overrides everything, including a pulse or hold-off in progress, which aborts immediately.
- After reset the previous-level register is 0. A level held at 1 through reset is therefore seen as a rising edge on the first cycle after reset once the synchroniser fills.
- Synchroniser: level[i] shifts through SYNC_STAGES flops. The last flop output is s[i]; with SYNC_STAGES=0, s[i]=level[i].
- Previous level: p[i] registers s[i] every cycle, in every state.
- Edge detect is combinational, per mode:
  - rise = s & ~p; fall = ~s & p.
  - 00 selects rise, 01 selects fall, 10 selects rise|fall, 11 gives edge=0.
- Latency: let E0 be the first clk edge that samples the new level value. pulse rises on edge E0+SYNC_STAGES.
  - SYNC_STAGES=0: pulse rises on E0.
  - SYNC_STAGES=2: pulse rises two edges after E0.
- Per-channel FSM, with a counter of width $clog2(max(PULSE_WIDTH,HOLDOFF)+1):
  - IDLE: on edge, go to PULSE, set pulse=1, load the counter with PULSE_WIDTH-1.
  - PULSE: when the counter is nonzero, decrement it.
  - PULSE at counter 0: if HOLDOFF=0, go to IDLE with pulse=0; otherwise go to HOLD with pulse=0 and load the counter with HOLDOFF-1.
  - PULSE with RETRIGGER=1: an edge reloads the counter to PULSE_WIDTH-1 and stays in PULSE. This takes priority over expiry in the same cycle.
  - HOLD: edges are ignored; the counter decrements and the FSM goes to IDLE when it reaches 0.
- An edge arriving in the same cycle that HOLD expires is ignored. Only edges seen while in IDLE start a pulse.
- Edges ignored in PULSE (RETRIGGER=0) or in HOLD are discarded, not queued.
- busy=1 exactly in PULSE or HOLD.
- A mode change takes effect on the next edge detect. It never truncates a pulse or hold-off already running.
- Setting mode=11 mid-pulse lets the pulse and hold-off complete; p[i] keeps tracking s[i], so re-enabling does not create a stale edge.
- Channels are fully independent. Simultaneous edges on several channels each produce their own pulse in the same cycle.
- PULSE_WIDTH=1, HOLDOFF=0 reproduces the legacy one-shot: a one-cycle pulse per qualifying edge.

Test Plan:
- Defaults (CH=4, SYNC=2, PW=1), mode=0, level[0] 0->1 sampled at edge 10 and held 1 -> pulse[0]=1 only during the cycle after edge 12; busy[0] follows pulse[0]; no further pulse while the level stays high.
- mode[1]=10 (both), level[1] high for 6 cycles then low -> exactly two 1-cycle pulses, 6 cycles apart; any_pulse mirrors them.
- PW=4, HOLDOFF=3, RETRIGGER=0, mode=00, rising edges at cycles 0 and 3 -> pulse high for 4 cycles, busy high for 7, second edge ignored; a new edge at cycle 8 produces a new pulse.
- PW=4, RETRIGGER=1, rising edges 2 cycles apart (mode=10, toggling level) -> pulse stays high continuously; it drops 4 cycles after the last edge.
- Assert rst for 1 cycle mid-pulse (PW=4), level held 1 -> pulse and busy clear on the rst edge; a fresh pulse appears SYNC_STAGES+1 cycles after rst deasserts (spurious-rise-after-reset rule).
- mode=11 on ch2 with level toggling each cycle -> pulse[2] stays 0. Switching to mode=00 while level is steady high produces no pulse until the next genuine rising edge.

Source files
------------

// File: rtl/multi_edge_pulse.sv
// Multi-channel edge-to-pulse one-shot: optional input synchroniser, per-channel
// edge select, programmable pulse width, post-pulse hold-off and optional retrigger.
module multi_edge_pulse #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_WIDTH = 1,
    parameter int HOLDOFF     = 0,
    parameter int RETRIGGER   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   level,
    input  logic [2*CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   busy,
    output logic                  any_pulse
);
    localparam int MAXCNT = (PULSE_WIDTH > HOLDOFF) ? PULSE_WIDTH : HOLDOFF;
    localparam int CW     = $clog2(MAXCNT + 1);
    localparam logic [CW-1:0] PW_LOAD = CW'(PULSE_WIDTH - 1);
    localparam logic [CW-1:0] HO_LOAD = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic          s;
        logic          p;
        logic          edge_det;
        logic          pulse_r;
        logic          busy_r;
        logic [CW-1:0] cnt;
        state_t        state;

        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sync;
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync <= '0;
                end else begin
                    sync[0] <= level[i];
                    for (int unsigned k = 1; k < SYNC_STAGES; k++)
                        sync[k] <= sync[k-1];
                end
            end
            assign s = sync[SYNC_STAGES-1];
        end else begin : g_nosync
            assign s = level[i];
        end

        // Mode is read live, so a change only affects the next edge decision.
        always_comb begin
            edge_det = 1'b0;
            case (mode[2*i +: 2])
                2'b00:   edge_det = s & ~p;
                2'b01:   edge_det = ~s & p;
                2'b10:   edge_det = s ^ p;
                default: edge_det = 1'b0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                p       <= 1'b0;
                state   <= IDLE;
                cnt     <= '0;
                pulse_r <= 1'b0;
                busy_r  <= 1'b0;
            end else begin
                p <= s;
                case (state)
                    IDLE: begin
                        if (edge_det) begin
                            state   <= PULSE;
                            cnt     <= PW_LOAD;
                            pulse_r <= 1'b1;
                            busy_r  <= 1'b1;
                        end
                    end
                    PULSE: begin
                        // A retrigger edge wins over expiry in the same cycle.
                        if (RETRIGGER != 0 && edge_det) begin
                            cnt <= PW_LOAD;
                        end else if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else if (HOLDOFF == 0) begin
                            state   <= IDLE;
                            pulse_r <= 1'b0;
                            busy_r  <= 1'b0;
                        end else begin
                            state   <= HOLD;
                            pulse_r <= 1'b0;
                            cnt     <= HO_LOAD;
                        end
                    end
                    HOLD: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        cnt     <= '0;
                        pulse_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end

        assign pulse[i] = pulse_r;
        assign busy[i]  = busy_r;
    end

    assign any_pulse = |pulse;

endmodule
